// File: rtl/dsp_frame_pkg.sv
// rtl/dsp_frame_pkg.sv - shared types and helpers for the DSP frame writer
package dsp_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_CH_PRE,
        S_CH_UDC,
        S_CH_DATA,
        S_CH_SUM,
        S_DONE
    } state_t;

    // Number of DSP RAM words in one frame
    function automatic int frame_words(input int hdr_words, input int num_ch, input int ch_data);
        return hdr_words + 2 + num_ch * (ch_data + 2);
    endfunction

    function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [15:0] word);
        return acc + word;
    endfunction

    function automatic logic [15:0] csum_final(input logic [15:0] acc);
        return ~acc;
    endfunction

endpackage

// File: rtl/dsp_frame_writer_if.sv
// rtl/dsp_frame_writer_if.sv - DSP-side RAM write bus and interrupt handshake
interface dsp_frame_writer_if #(
    parameter int AW = 10,
    parameter int DW = 16
);
    logic          o_ram_wea;
    logic [AW-1:0] o_ram_addr;
    logic [DW-1:0] o_ram_data;
    logic          XINT1W;
    logic          XRD;

    modport master (output o_ram_wea, o_ram_addr, o_ram_data, XINT1W, input XRD);
    modport slave  (input o_ram_wea, o_ram_addr, o_ram_data, XINT1W, output XRD);
endinterface

// File: rtl/int_stretcher.sv
// rtl/int_stretcher.sv - stretches a one-clock irq into a timed DSP interrupt
module int_stretcher #(
    parameter int INT_CYCLES = 242
) (
    input  logic clk,
    input  logic rst,
    input  logic i_irq,
    input  logic i_xrd_n,
    output logic o_xint
);
    localparam int CW = $clog2(INT_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_xint;

    // A new irq always restarts the window; a DSP read ends it early
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xint <= 1'b0;
            r_cnt  <= '0;
        end else if (i_irq) begin
            r_xint <= 1'b1;
            r_cnt  <= CW'(INT_CYCLES - 1);
        end else if (r_xint) begin
            if (!i_xrd_n || r_cnt == '0) begin
                r_xint <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_xint = r_xint;
endmodule

// File: rtl/dsp_frame_writer.sv
// rtl/dsp_frame_writer.sv - snapshots header/udc and streams one frame into DSP RAM
module dsp_frame_writer
    import dsp_frame_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int HDR_WORDS  = 12,
    parameter int CH_DATA    = 78,
    parameter int BASE_ADDR  = 'h100,
    parameter int AW         = 10,
    parameter int DW         = 16,
    parameter int INT_CYCLES = 242
) (
    input  logic                   clk_100M,
    input  logic                   reset,
    input  logic                   start,
    input  logic [HDR_WORDS*DW-1:0] hdr_data,
    input  logic [NUM_CH*DW-1:0]   ch_udc,
    output logic [NUM_CH*AW-1:0]   ch_rd_addr,
    input  logic [NUM_CH*DW-1:0]   ch_rd_data,
    dsp_frame_writer_if.master     dsp,
    output logic                   busy,
    output logic [15:0]            frame_cnt,
    output logic [15:0]            overrun_cnt
);
    localparam int             CW        = 16;
    localparam logic [CW-1:0]  HDR_FC    = CW'(HDR_WORDS);
    localparam logic [CW-1:0]  HDR_LAST  = CW'(HDR_WORDS + 1);
    localparam logic [CW-1:0]  DATA_LAST = CW'(CH_DATA - 1);
    localparam logic [2:0]     CH_LAST   = 3'(NUM_CH - 1);
    localparam logic [AW-1:0]  ADDR0     = AW'(BASE_ADDR);

    if (BASE_ADDR + frame_words(HDR_WORDS, NUM_CH, CH_DATA) - 1 >= (1 << AW)) begin : g_bad_range
        $fatal(1, "frame does not fit in the DSP RAM address space");
    end
    if (DW != 16 || NUM_CH < 1 || NUM_CH > 8) begin : g_bad_shape
        $fatal(1, "unsupported word width or channel count");
    end

    state_t                  r_state, w_next;
    logic                    r_start_q;
    logic [HDR_WORDS*DW-1:0] r_hdr;
    logic [NUM_CH*DW-1:0]    r_udc;
    logic [CW-1:0]           r_cnt;
    logic [2:0]              r_ch;
    logic [AW-1:0]           r_addr;
    logic [15:0]             r_sum, r_frame_cnt, r_overrun;
    logic [DW-1:0]           r_rd_q;

    logic                    w_edge, w_wea, w_irq, w_busy, w_sum_word, w_xint;
    logic [DW-1:0]           w_data;
    logic [AW-1:0]           w_rd_addr;
    logic [CW-1:0]           w_hidx;

    assign w_edge     = start & ~r_start_q;
    assign w_hidx     = (r_cnt < HDR_FC) ? r_cnt : '0;
    assign w_sum_word = (r_state == S_HDR && r_cnt == HDR_LAST) || (r_state == S_CH_SUM);

    // State register
    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state and per-state write word; RAM read data is registered once more
    // inside the writer, so the channel address runs two words ahead of the write
    always_comb begin
        w_next    = r_state;
        w_wea     = 1'b0;
        w_data    = '0;
        w_rd_addr = '0;
        w_irq     = 1'b0;
        w_busy    = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_edge) w_next = S_HDR;
            end
            S_HDR: begin
                w_wea = 1'b1;
                if (r_cnt < HDR_FC)       w_data = r_hdr[w_hidx*DW +: DW];
                else if (r_cnt == HDR_FC) w_data = r_frame_cnt;
                else                      w_data = csum_final(r_sum);
                if (r_cnt == HDR_LAST) w_next = S_CH_PRE;
            end
            S_CH_PRE: begin
                w_rd_addr = AW'(1);
                w_next    = S_CH_UDC;
            end
            S_CH_UDC: begin
                w_wea     = 1'b1;
                w_data    = r_udc[r_ch*DW +: DW];
                w_rd_addr = AW'(2);
                w_next    = S_CH_DATA;
            end
            S_CH_DATA: begin
                w_wea     = 1'b1;
                w_data    = r_rd_q;
                w_rd_addr = AW'(3) + r_cnt[AW-1:0];
                if (r_cnt == DATA_LAST) w_next = S_CH_SUM;
            end
            S_CH_SUM: begin
                w_wea  = 1'b1;
                w_data = csum_final(r_sum);
                w_next = (r_ch == CH_LAST) ? S_DONE : S_CH_PRE;
            end
            S_DONE: begin
                w_busy = 1'b0;
                w_irq  = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // Frame datapath: snapshot, counters, running checksum, write address
    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset) begin
            r_start_q   <= 1'b1;
            r_hdr       <= '0;
            r_udc       <= '0;
            r_cnt       <= '0;
            r_ch        <= '0;
            r_addr      <= ADDR0;
            r_sum       <= '0;
            r_rd_q      <= '0;
            r_frame_cnt <= '0;
            r_overrun   <= '0;
        end else begin
            r_start_q <= start;
            r_rd_q    <= ch_rd_data[r_ch*DW +: DW];
            r_cnt     <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
            r_sum     <= (w_wea && !w_sum_word) ? csum_add(r_sum, w_data) : '0;
            if (r_state == S_IDLE) r_addr <= ADDR0;
            else if (w_wea)        r_addr <= r_addr + 1'b1;
            if (r_state == S_IDLE)                          r_ch <= '0;
            else if (r_state == S_CH_SUM && r_ch != CH_LAST) r_ch <= r_ch + 1'b1;
            if (r_state == S_IDLE && w_edge) begin
                r_hdr       <= hdr_data;
                r_udc       <= ch_udc;
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            if (w_edge && w_busy && r_overrun != 16'hFFFF) r_overrun <= r_overrun + 1'b1;
        end
    end

    // Only the channel being read sees a non-zero address
    always_comb begin
        ch_rd_addr = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_ch == 3'(c)) ch_rd_addr[c*AW +: AW] = w_rd_addr;
        end
    end

    int_stretcher #(.INT_CYCLES(INT_CYCLES)) u_int (
        .clk     (clk_100M),
        .rst     (reset),
        .i_irq   (w_irq),
        .i_xrd_n (dsp.XRD),
        .o_xint  (w_xint)
    );

    assign dsp.o_ram_wea  = w_wea;
    assign dsp.o_ram_data = w_data;
    assign dsp.o_ram_addr = (r_state == S_IDLE || r_state == S_DONE) ? '0 : r_addr;
    assign dsp.XINT1W     = w_xint;
    assign busy           = w_busy;
    assign frame_cnt      = r_frame_cnt;
    assign overrun_cnt    = r_overrun;
endmodule

// File: tb/tb_dsp_frame_writer.sv
// tb/tb_dsp_frame_writer.sv - scoreboard bench for dsp_frame_writer
module tb_dsp_frame_writer;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int M_NCH = 3, M_HDR = 12, M_CHD = 78;
    localparam int S_NCH = 1, S_HDR = 2,  S_CHD = 4;

    logic clk_100M = 1'b0;
    always #5 clk_100M = ~clk_100M;

    logic reset, m_start, s_start;
    logic [M_HDR*DW-1:0] m_hdr;
    logic [M_NCH*DW-1:0] m_udc, m_rd_data;
    logic [M_NCH*AW-1:0] m_rd_addr;
    logic                m_busy;
    logic [15:0]         m_fcnt, m_ovr;
    logic [S_HDR*DW-1:0] s_hdr;
    logic [S_NCH*DW-1:0] s_udc, s_rd_data;
    logic [S_NCH*AW-1:0] s_rd_addr;
    logic                s_busy;
    logic [15:0]         s_fcnt, s_ovr;

    dsp_frame_writer_if #(.AW(AW), .DW(DW)) m_if ();
    dsp_frame_writer_if #(.AW(AW), .DW(DW)) s_if ();

    dsp_frame_writer u_m (
        .clk_100M(clk_100M), .reset(reset), .start(m_start), .hdr_data(m_hdr), .ch_udc(m_udc),
        .ch_rd_addr(m_rd_addr), .ch_rd_data(m_rd_data), .dsp(m_if.master), .busy(m_busy),
        .frame_cnt(m_fcnt), .overrun_cnt(m_ovr)
    );

    dsp_frame_writer #(.NUM_CH(S_NCH), .HDR_WORDS(S_HDR), .CH_DATA(S_CHD)) u_s (
        .clk_100M(clk_100M), .reset(reset), .start(s_start), .hdr_data(s_hdr), .ch_udc(s_udc),
        .ch_rd_addr(s_rd_addr), .ch_rd_data(s_rd_data), .dsp(s_if.master), .busy(s_busy),
        .frame_cnt(s_fcnt), .overrun_cnt(s_ovr)
    );

    // channel receive RAMs: 1-clock latency, content addr + 0x100*c
    always @(posedge clk_100M) begin
        for (int c = 0; c < M_NCH; c++)
            m_rd_data[c*DW +: DW] <= {6'b0, m_rd_addr[c*AW +: AW]} + 16'(c * 256);
    end
    assign s_rd_data = 16'hFFFF;

    int checks = 0, errors = 0;
    int m_writes = 0, s_writes = 0, m_busy_run = 0, s_busy_run = 0, m_rises = 0;
    logic m_xint_prev = 1'b0;
    logic [31:0] q_m[$], q_s[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int sel, input logic [9:0] a, input logic [15:0] w);
        if (sel == 0) q_m.push_back({6'b0, a, w});
        else          q_s.push_back({6'b0, a, w});
    endtask

    // expected frame: hdr k = k+1, udc = A000+c, data = j+0x100*c (main) or FFFF (small)
    task automatic push_frame(input int sel, input logic [15:0] fcnt);
        int nch, hdr, chd;
        logic [15:0] sum, w;
        logic [9:0] a;
        nch = (sel == 0) ? M_NCH : S_NCH;
        hdr = (sel == 0) ? M_HDR : S_HDR;
        chd = (sel == 0) ? M_CHD : S_CHD;
        a = 10'h100;
        sum = 16'h0;
        for (int k = 0; k < hdr; k++) begin
            w = 16'(k + 1); push(sel, a, w); sum += w; a++;
        end
        push(sel, a, fcnt); sum += fcnt; a++;
        push(sel, a, ~sum); a++;
        for (int c = 0; c < nch; c++) begin
            sum = 16'hA000 + 16'(c); push(sel, a, sum); a++;
            for (int j = 1; j <= chd; j++) begin
                w = (sel == 0) ? 16'(j + 256 * c) : 16'hFFFF;
                push(sel, a, w); sum += w; a++;
            end
            push(sel, a, ~sum); a++;
        end
    endtask

    // scoreboard monitors: pop and compare on every DSP RAM write
    always @(negedge clk_100M) begin
        logic [31:0] e;
        if (m_busy === 1'b1) m_busy_run++;
        if (s_busy === 1'b1) s_busy_run++;
        if (m_if.XINT1W === 1'b1 && !m_xint_prev) m_rises++;
        m_xint_prev = (m_if.XINT1W === 1'b1);
        if (m_if.o_ram_wea === 1'b1) begin
            m_writes++;
            if (q_m.size() == 0) begin
                checks++; errors++;
                $display("FAIL m_write unexpected: got %h/%h expected none", m_if.o_ram_addr, m_if.o_ram_data);
            end else begin
                e = q_m.pop_front();
                check("m_write", {6'b0, m_if.o_ram_addr, m_if.o_ram_data}, e);
            end
        end
        if (s_if.o_ram_wea === 1'b1) begin
            s_writes++;
            if (q_s.size() == 0) begin
                checks++; errors++;
                $display("FAIL s_write unexpected: got %h/%h expected none", s_if.o_ram_addr, s_if.o_ram_data);
            end else begin
                e = q_s.pop_front();
                check("s_write", {6'b0, s_if.o_ram_addr, s_if.o_ram_data}, e);
            end
        end
    end

    task automatic pulse(input int sel);
        if (sel == 0) m_start = 1'b1; else s_start = 1'b1;
        @(negedge clk_100M);
        if (sel == 0) m_start = 1'b0; else s_start = 1'b0;
    endtask

    task automatic wait_idle(input int sel, input string name);
        int n = 0;
        while (((sel == 0) ? m_busy : s_busy) !== 1'b0 && n < 5000) begin
            @(negedge clk_100M); n++;
        end
        if (n >= 5000) begin
            checks++; errors++;
            $display("FAIL %s: got timeout expected busy low", name);
        end
        @(negedge clk_100M);
    endtask

    task automatic wait_xint_rise(input string name);
        int n = 0;
        while (m_if.XINT1W !== 1'b1 && n < 50) begin
            @(negedge clk_100M); n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL %s: got no rise expected XINT1W high", name);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_wea"}, {31'b0, m_if.o_ram_wea}, 32'h0);
        check({name, "_addr"}, {22'b0, m_if.o_ram_addr}, 32'h0);
        check({name, "_data"}, {16'b0, m_if.o_ram_data}, 32'h0);
        check({name, "_busy"}, {31'b0, m_busy}, 32'h0);
        check({name, "_fcnt"}, {16'b0, m_fcnt}, 32'h0);
        check({name, "_ovr"}, {16'b0, m_ovr}, 32'h0);
        check({name, "_rdaddr"}, {2'b0, m_rd_addr}, 32'h0);
        check({name, "_xint"}, {31'b0, m_if.XINT1W}, 32'h0);
    endtask

    initial begin
        int hi;
        reset = 1'b1; m_start = 1'b1; s_start = 1'b0;
        m_if.XRD = 1'b1; s_if.XRD = 1'b1;
        for (int k = 0; k < M_HDR; k++) m_hdr[k*DW +: DW] = 16'(k + 1);
        for (int k = 0; k < S_HDR; k++) s_hdr[k*DW +: DW] = 16'(k + 1);
        for (int c = 0; c < M_NCH; c++) m_udc[c*DW +: DW] = 16'hA000 + 16'(c);
        s_udc = 16'hA000;
        repeat (3) @(negedge clk_100M);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (3) @(negedge clk_100M);
        check("start_held_through_reset", {31'b0, m_busy}, 32'h0);
        m_start = 1'b0;
        @(negedge clk_100M);

        // frame 1 with rejected starts while busy
        m_writes = 0; m_busy_run = 0;
        push_frame(0, 16'h0001);
        pulse(0);
        repeat (9) @(negedge clk_100M);
        pulse(0);
        @(negedge clk_100M);
        check("overrun_one", {16'b0, m_ovr}, 32'd1);
        check("fcnt_unchanged", {16'b0, m_fcnt}, 32'd1);
        pulse(0); @(negedge clk_100M);
        pulse(0); @(negedge clk_100M);
        check("overrun_three", {16'b0, m_ovr}, 32'd3);
        wait_idle(0, "frame1_done");
        check("frame1_busy_clocks", m_busy_run, 32'd257);
        check("frame1_writes", m_writes, 32'd254);
        check("frame1_drained", q_m.size(), 32'd0);
        wait_xint_rise("frame1_xint");
        hi = 0;
        while (m_if.XINT1W === 1'b1 && hi < 400) begin
            @(negedge clk_100M); hi++;
        end
        check("xint_high_clocks", hi, 32'd242);

        // frame 2: early release on XRD
        push_frame(0, 16'h0002);
        pulse(0);
        wait_idle(0, "frame2_done");
        wait_xint_rise("frame2_xint");
        repeat (19) @(negedge clk_100M);
        check("xint_before_xrd", {31'b0, m_if.XINT1W}, 32'h1);
        m_if.XRD = 1'b0;
        @(negedge clk_100M);
        check("xint_after_xrd", {31'b0, m_if.XINT1W}, 32'h0);
        m_if.XRD = 1'b1;
        hi = m_rises;
        repeat (300) @(negedge clk_100M);
        check("xint_no_second_rise", m_rises, hi);

        // frame 3: reset in the middle of channel 1 data
        push_frame(0, 16'h0003);
        pulse(0);
        hi = 0;
        while (!(m_if.o_ram_wea === 1'b1 && m_if.o_ram_addr === 10'h165) && hi < 500) begin
            @(negedge clk_100M); hi++;
        end
        check("ch1_rd_addr_ahead", {22'b0, m_rd_addr[AW +: AW]}, 32'd9);
        check("inactive_ch_zero", {12'b0, m_rd_addr[2*AW +: AW], m_rd_addr[0 +: AW]}, 32'h0);
        #1 reset = 1'b1;
        #1 check_all_zero("midframe_reset");
        q_m.delete();
        @(negedge clk_100M);
        reset = 1'b0;
        @(negedge clk_100M);
        m_writes = 0;
        push_frame(0, 16'h0001);
        pulse(0);
        wait_idle(0, "frame4_done");
        check("frame4_writes", m_writes, 32'd254);
        check("frame4_drained", q_m.size(), 32'd0);
        check("frame4_fcnt", {16'b0, m_fcnt}, 32'd1);

        // small configuration with all-ones channel data
        s_writes = 0; s_busy_run = 0;
        push_frame(1, 16'h0001);
        pulse(1);
        wait_idle(1, "small_done");
        check("small_busy_clocks", s_busy_run, 32'd11);
        check("small_writes", s_writes, 32'd10);
        check("small_drained", q_s.size(), 32'd0);

        // frame counter wrap
        force u_s.r_frame_cnt = 16'hFFFF;
        @(negedge clk_100M);
        release u_s.r_frame_cnt;
        @(negedge clk_100M);
        push_frame(1, 16'h0000);
        pulse(1);
        wait_idle(1, "wrap_done");
        check("wrap_fcnt", {16'b0, s_fcnt}, 32'h0);
        check("wrap_drained", q_s.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dsp_frame_writer.md
Name: dsp_frame_writer

Overview:
Parametrised successor of the DSP-side DPRAM frame writer. On a start edge it snapshots a header vector and streams one contiguous frame into the DSP interface RAM:
- a header block,
- then NUM_CH phase blocks, each made of a udc word, data read from that channel's receive RAM, and an inverted-sum checksum.

After the last word it raises a stretched interrupt to the DSP. It adds a busy flag, overrun counting, and early interrupt release on the DSP read strobe.

Parameters:
NUM_CH, 3, number of phase channels (1..8)
HDR_WORDS, 12, header input words, excluding the frame-counter and checksum words
CH_DATA, 78, data words read per channel, from channel RAM addresses 1..CH_DATA
BASE_ADDR, 10'h100, first DSP RAM address of the frame
AW, 10, address width for DSP RAM and channel RAMs
DW, 16, data width
INT_CYCLES, 242, XINT1W high time in clocks (2.42 us at 100 MHz)

Ports:
clk_100M  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  frame request; rising edge triggers a frame
hdr_data  in  HDR_WORDS*DW  header words; word k at [k*DW +: DW]
ch_udc  in  NUM_CH*DW  per-channel DC-link voltage word
ch_rd_addr  out  NUM_CH*AW  per-channel receive RAM read address
ch_rd_data  in  NUM_CH*DW  per-channel receive RAM data, 1-clock read latency
o_ram_wea  out  1  DSP RAM write enable
o_ram_addr  out  AW  DSP RAM address
o_ram_data  out  DW  DSP RAM write data
XINT1W  out  1  DSP interrupt, stretched
XRD  in  1  DSP read strobe, active-low
busy  out  1  frame in progress
frame_cnt  out  16  FPGA renewal counter
overrun_cnt  out  16  starts rejected while busy, saturating

Behaviour:
Reset (asynchronous, active-high): all outputs 0, FSM in IDLE, internal start_q=1 so that start held high during reset does not trigger.

Start edge:
- Edge = start & ~start_q.
- Accepted only in IDLE. On acceptance, in the same clock: snapshot hdr_data and ch_udc; frame_cnt+=1 (wraps FFFF->0); busy=1; go to HDR.
- Edge while busy: frame is not restarted; overrun_cnt+=1, saturating at FFFF.

Frame layout (16-bit words, contiguous from BASE_ADDR, one write per clock):
- Header block, HDR_WORDS+2 words: snapshot words 0..HDR_WORDS-1, then frame_cnt (post-increment value), then ~(mod-2^16 sum of those HDR_WORDS+1 words).
- Channel block c, CH_DATA+2 words, in order c=0..NUM_CH-1: udc snapshot c, then ch_rd_data c for addresses 1..CH_DATA, then ~(udc + sum of the data words), mod 2^16.
- Total words T = HDR_WORDS+2 + NUM_CH*(CH_DATA+2). Defaults give T=254, last address 0x1FD.
- BASE_ADDR+T-1 must be < 2^AW; violation is a $fatal at elaboration.

FSM: IDLE -> HDR -> {CH_PRE -> CH_UDC -> CH_DATA -> CH_SUM} per channel -> DONE -> IDLE.
- HDR: writes the header block, HDR_WORDS+2 clocks; first write at BASE_ADDR in the clock after acceptance.
- CH_PRE: drives ch_rd_addr[c]=1; o_ram_wea=0 for this one clock.
- CH_UDC: writes the udc word; ch_rd_addr[c]=2.
- CH_DATA: writes ch_rd_data[c] and increments ch_rd_addr[c] each clock, CH_DATA clocks.
- CH_SUM: writes the checksum. Then c+1 -> CH_PRE, or last channel -> DONE.
- DONE: o_ram_wea=0, o_ram_addr/o_ram_data=0, busy=0, pulse internal irq for 1 clock.
- Frame duration from acceptance to DONE: T + NUM_CH + 1 clocks.
- ch_rd_addr of inactive channels = 0.
- o_ram_addr/o_ram_data are 0 whenever in IDLE.

Interrupt:
- XINT1W rises the clock after the irq pulse and stays high for INT_CYCLES clocks.
- XRD sampled low while XINT1W is high -> XINT1W low next clock.
- A new irq pulse while XINT1W is high restarts the count.

A new start accepted in IDLE while XINT1W is still high is legal; the interrupt counter is unaffected.

Decomposition:
- Package dsp_frame_pkg: FSM state enum; function frame_words(HDR_WORDS, NUM_CH, CH_DATA); 16-bit checksum add/invert function.
- Sub-module int_stretcher (irq pulse, XRD, INT_CYCLES -> XINT1W): one natural sub-module.

Test Plan:
- Defaults; hdr word k = k+1; udc = 16'hA000+c; channel RAM models return addr+16'h100*c; one start edge -> exactly 254 writes at 0x100..0x1FD with frame_cnt=1 at 0x10C, ~sum at 0x10D, matching channel checksums; XINT1W high for 242 clocks.
- Start edge 10 clocks after acceptance -> frame unchanged, overrun_cnt=1, frame_cnt stays 1; 3 rejected starts -> overrun_cnt=3.
- XRD driven low 20 clocks after XINT1W rises -> XINT1W low on clock 21; no second rise.
- reset asserted mid CH_DATA of channel 1 -> all outputs 0 immediately; next start writes a full frame with frame_cnt=1.
- NUM_CH=1, CH_DATA=4, HDR_WORDS=2 -> T=10, 11 clocks busy-to-DONE; checksum wrap case with data 16'hFFFF x4 checksums to ~(udc+16'hFFFC).
- frame_cnt preloaded to FFFF via 65535 frames (or force) -> next frame writes 0x0000 and the header checksum is consistent.
